// File: rtl/sequential_divider_pkg.sv
// Shared types and constants for the restoring sequential divider.
// Also carries a behavioural reference divide for benches.
package sequential_divider_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 dz;
  } div_result_t;

  // A zero divisor yields an all-ones quotient and returns the dividend as remainder.
  function automatic div_result_t ref_divide(input logic [DIV_WIDTH-1:0] dividend,
                                             input logic [DIV_WIDTH-1:0] divisor);
    div_result_t res;
    if (divisor == '0) begin
      res.quotient  = '1;
      res.remainder = dividend;
      res.dz        = 1'b1;
    end else begin
      res.quotient  = dividend / divisor;
      res.remainder = dividend % divisor;
      res.dz        = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Operand/result bus shared by the divider and its multiplicator sibling.
// Handshake: start_in is a level request accepted on a rising edge in IDLE or DONE;
// results are valid while done_out=1 and are held until the next accepted start.
interface sequential_divider_if #(parameter int WIDTH = 8) ();
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic             start_in;
  logic [WIDTH-1:0] quotient_out;
  logic [WIDTH-1:0] remainder_out;
  logic             done_out;
  logic             div_by_zero_out;

  modport master (
    output dividend_in, divisor_in, start_in,
    input  quotient_out, remainder_out, done_out, div_by_zero_out
  );

  modport slave (
    input  dividend_in, divisor_in, start_in,
    output quotient_out, remainder_out, done_out, div_by_zero_out
  );
endinterface

// File: rtl/sequential_divider_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, restore on borrow.
module sequential_divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH+1:0] r_sh;
  logic             fits;

  always_comb begin
    r_sh = {r_i, q_i[WIDTH-1]};
    fits = (r_sh >= {2'b00, d_i});
    r_o  = fits ? (r_sh[WIDTH:0] - {1'b0, d_i}) : r_sh[WIDTH:0];
    q_o  = {q_i[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
// Three-process FSM (IDLE/CALC/DONE); state is exported on state_o for observation.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  sequential_divider_if.slave bus,
  output div_state_t         state_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;
  logic             accept, accept_dz, last_step;

  sequential_divider_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  assign accept    = bus.start_in && (state_q != CALC);
  assign accept_dz = accept && (bus.divisor_in == '0);
  assign last_step = (state_q == CALC) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept) state_d = accept_dz ? DONE : CALC;
      CALC:       if (last_step) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Divide-by-zero is resolved on the accepting edge and never enters CALC.
  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    done_d = done_q;
    dz_d   = dz_q;
    if (accept) begin
      if (accept_dz) begin
        quot_d = '1;
        rem_d  = bus.dividend_in;
        dz_d   = 1'b1;
        done_d = 1'b1;
      end else begin
        r_d    = '0;
        q_d    = bus.dividend_in;
        d_d    = bus.divisor_in;
        cnt_d  = '0;
        done_d = 1'b0;
      end
    end else if (state_q == CALC) begin
      r_d   = step_r;
      q_d   = step_q;
      cnt_d = cnt_q + 1'b1;
      if (last_step) begin
        quot_d = step_q;
        rem_d  = step_r[WIDTH-1:0];
        dz_d   = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign bus.quotient_out    = quot_q;
  assign bus.remainder_out   = rem_q;
  assign bus.done_out        = done_q;
  assign bus.div_by_zero_out = dz_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and table-driven checks of sequential_divider at WIDTH=8.
module tb_sequential_divider;
  import sequential_divider_pkg::*;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  div_state_t dbg_state;
  int         checks;
  int         failures;

  sequential_divider_if #(.WIDTH(W)) bus ();

  sequential_divider #(.WIDTH(W)) dut (
    .clock   (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one request; edges counts rising edges from the accepting edge (=1) to done.
  task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        output int edges, output logic done_at_accept);
    @(negedge clk);
    bus.dividend_in = dvd;
    bus.divisor_in  = dvs;
    bus.start_in    = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    bus.start_in   = 1'b0;
    done_at_accept = bus.done_out;
    while (bus.done_out !== 1'b1 && edges < 30) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.start_in    = 1'b0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.done_out !== 1'b0) begin failures++; $display("FAIL reset_done got %0d expected 0", bus.done_out); end
    checks++;
    if (bus.quotient_out !== 8'd0) begin failures++; $display("FAIL reset_quot got %0d expected 0", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd0) begin failures++; $display("FAIL reset_rem got %0d expected 0", bus.remainder_out); end
    checks++;
    if (bus.div_by_zero_out !== 1'b0) begin failures++; $display("FAIL reset_dz got %0d expected 0", bus.div_by_zero_out); end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.done_out !== 1'b0) begin failures++; $display("FAIL idle_done got %0d expected 0", bus.done_out); end
  endtask

  task automatic test_basic();
    int   edges;
    logic dacc;
    run_op(8'd100, 8'd7, edges, dacc);
    checks++;
    if (edges != 9) begin failures++; $display("FAIL basic_latency got %0d expected 9", edges); end
    checks++;
    if (bus.quotient_out !== 8'd14) begin failures++; $display("FAIL basic_quot got %0d expected 14", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd2) begin failures++; $display("FAIL basic_rem got %0d expected 2", bus.remainder_out); end
    checks++;
    if (bus.div_by_zero_out !== 1'b0) begin failures++; $display("FAIL basic_dz got %0d expected 0", bus.div_by_zero_out); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.done_out !== 1'b1) begin failures++; $display("FAIL basic_hold_done got %0d expected 1", bus.done_out); end
    checks++;
    if (bus.quotient_out !== 8'd14) begin failures++; $display("FAIL basic_hold_quot got %0d expected 14", bus.quotient_out); end
  endtask

  task automatic test_back_to_back();
    int   edges;
    logic dacc;
    run_op(8'd255, 8'd1, edges, dacc);
    checks++;
    if (bus.quotient_out !== 8'd255) begin failures++; $display("FAIL div1_quot got %0d expected 255", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd0) begin failures++; $display("FAIL div1_rem got %0d expected 0", bus.remainder_out); end
    run_op(8'd5, 8'd9, edges, dacc);
    checks++;
    if (dacc !== 1'b0) begin failures++; $display("FAIL restart_done_drop got %0d expected 0", dacc); end
    checks++;
    if (edges != 9) begin failures++; $display("FAIL restart_latency got %0d expected 9", edges); end
    checks++;
    if (bus.quotient_out !== 8'd0) begin failures++; $display("FAIL small_quot got %0d expected 0", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd5) begin failures++; $display("FAIL small_rem got %0d expected 5", bus.remainder_out); end
  endtask

  task automatic test_div_zero();
    int   edges;
    logic dacc;
    run_op(8'hA5, 8'd0, edges, dacc);
    checks++;
    if (edges != 1) begin failures++; $display("FAIL dz_latency got %0d expected 1", edges); end
    checks++;
    if (bus.quotient_out !== 8'hFF) begin failures++; $display("FAIL dz_quot got %0h expected ff", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'hA5) begin failures++; $display("FAIL dz_rem got %0h expected a5", bus.remainder_out); end
    checks++;
    if (bus.div_by_zero_out !== 1'b1) begin failures++; $display("FAIL dz_flag got %0d expected 1", bus.div_by_zero_out); end
    run_op(8'h33, 8'd0, edges, dacc);
    checks++;
    if (dacc !== 1'b1) begin failures++; $display("FAIL dz_restart_done got %0d expected 1", dacc); end
    checks++;
    if (bus.remainder_out !== 8'h33) begin failures++; $display("FAIL dz_restart_rem got %0h expected 33", bus.remainder_out); end
    run_op(8'd200, 8'd10, edges, dacc);
    checks++;
    if (bus.div_by_zero_out !== 1'b0) begin failures++; $display("FAIL dz_clear got %0d expected 0", bus.div_by_zero_out); end
    checks++;
    if (bus.quotient_out !== 8'd20) begin failures++; $display("FAIL after_dz_quot got %0d expected 20", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd0) begin failures++; $display("FAIL after_dz_rem got %0d expected 0", bus.remainder_out); end
  endtask

  task automatic test_ignore_start();
    int edges;
    @(negedge clk);
    bus.dividend_in = 8'd200;
    bus.divisor_in  = 8'd3;
    bus.start_in    = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    bus.start_in = 1'b0;
    repeat (2) begin @(posedge clk); edges++; end
    @(negedge clk);
    bus.dividend_in = 8'd50;
    bus.divisor_in  = 8'd5;
    bus.start_in    = 1'b1;
    @(posedge clk);
    edges++;
    #1;
    bus.start_in = 1'b0;
    while (bus.done_out !== 1'b1 && edges < 30) begin
      @(posedge clk);
      edges++;
      #1;
    end
    checks++;
    if (edges != 9) begin failures++; $display("FAIL ignore_latency got %0d expected 9", edges); end
    checks++;
    if (bus.quotient_out !== 8'd66) begin failures++; $display("FAIL ignore_quot got %0d expected 66", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd2) begin failures++; $display("FAIL ignore_rem got %0d expected 2", bus.remainder_out); end
  endtask

  task automatic test_reset_mid();
    int   edges;
    logic dacc;
    logic seen_done;
    @(negedge clk);
    bus.dividend_in = 8'd123;
    bus.divisor_in  = 8'd4;
    bus.start_in    = 1'b1;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.quotient_out !== 8'd0) begin failures++; $display("FAIL abort_quot got %0d expected 0", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd0) begin failures++; $display("FAIL abort_rem got %0d expected 0", bus.remainder_out); end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL abort_state got %0d expected %0d", dbg_state, IDLE); end
    @(negedge clk);
    reset     = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done_out === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got %0d expected 0", seen_done); end
    run_op(8'd123, 8'd4, edges, dacc);
    checks++;
    if (bus.quotient_out !== 8'd30) begin failures++; $display("FAIL rerun_quot got %0d expected 30", bus.quotient_out); end
    checks++;
    if (bus.remainder_out !== 8'd3) begin failures++; $display("FAIL rerun_rem got %0d expected 3", bus.remainder_out); end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [3];
    logic [W-1:0] dvd, dvs;
    div_result_t  exp_r;
    int           edges;
    logic         dacc;
    corner[0] = 8'd0;
    corner[1] = 8'd1;
    corner[2] = 8'd255;
    for (int i = 0; i < 1000; i++) begin
      if (i < 9) begin
        dvd = corner[i / 3];
        dvs = corner[i % 3];
      end else begin
        dvd = W'($urandom_range(0, 255));
        dvs = W'($urandom_range(0, 255));
      end
      exp_r = ref_divide(dvd, dvs);
      run_op(dvd, dvs, edges, dacc);
      checks++;
      if (bus.quotient_out !== exp_r.quotient) begin failures++; $display("FAIL rnd_quot %0d/%0d got %0d expected %0d", dvd, dvs, bus.quotient_out, exp_r.quotient); end
      checks++;
      if (bus.remainder_out !== exp_r.remainder) begin failures++; $display("FAIL rnd_rem %0d/%0d got %0d expected %0d", dvd, dvs, bus.remainder_out, exp_r.remainder); end
      checks++;
      if (bus.div_by_zero_out !== exp_r.dz) begin failures++; $display("FAIL rnd_dz %0d/%0d got %0d expected %0d", dvd, dvs, bus.div_by_zero_out, exp_r.dz); end
      checks++;
      if (edges != (exp_r.dz ? 1 : 9)) begin failures++; $display("FAIL rnd_latency %0d/%0d got %0d expected %0d", dvd, dvs, edges, exp_r.dz ? 1 : 9); end
      if (dvs != 0) begin
        checks++;
        if ((int'(bus.quotient_out) * int'(dvs) + int'(bus.remainder_out) != int'(dvd)) || (bus.remainder_out >= dvs)) begin
          failures++;
          $display("FAIL rnd_invariant %0d/%0d got q=%0d r=%0d", dvd, dvs, bus.quotient_out, bus.remainder_out);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
